// File: rtl/serial_add_shifter_if.sv
// ============================================================================
// Module      : serial_add_shifter_if
// Description : Bundles the host-side handshake (start/opa/opb/busy/sum/done/
//               mismatch) and the adder-side serial pins (a/b/s_in) of the
//               serial adder front-end.
// Ports       : start, opa[N-1:0], opb[N-1:0]  host request and operands
//               a, b                           serial operand bits to adder
//               s_in                           serial sum bit from adder
//               busy, done, sum[N:0], mismatch host status and result
// Modports    : slave  - the serial_add_shifter block
//               master - the environment (host and serial adder)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_add_shifter_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] opa;
  logic [N-1:0] opb;
  logic         a;
  logic         b;
  logic         s_in;
  logic         busy;
  logic [N:0]   sum;
  logic         done;
  logic         mismatch;

  modport slave (
    input  start, opa, opb, s_in,
    output a, b, busy, sum, done, mismatch
  );

  modport master (
    output start, opa, opb, s_in,
    input  a, b, busy, sum, done, mismatch
  );
endinterface

`default_nettype wire

// File: rtl/serial_add_shifter.sv
// ============================================================================
// Module      : serial_add_shifter
// Description : Front-end and collector for a two-state serial adder. Takes
//               two N-bit operands on a start strobe, drives them LSB-first
//               on a/b followed by one 0/0 flush pair, and reassembles the
//               returned serial sum into an (N+1)-bit result with a one-cycle
//               done pulse.
// Parameters  : N       - operand width (2..32)
//               SUM_LAT - 0: adder sum is combinational, 1: adder sum is
//                         registered (adds a DRAIN cycle)
// Ports       : clk_i   - clock, all logic on rising edge
//               rst_ni  - asynchronous active-low reset
//               bus     - serial_add_shifter_if.slave (see interface file)
// Options     : define SERIAL_ADD_SELFCHECK_EN to latch opa+opb on accept and
//               compare it with the collected sum at completion (mismatch).
//               Without it mismatch is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_shifter #(
  parameter int N       = 8,
  parameter int SUM_LAT = 1
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  serial_add_shifter_if.slave   bus
);

  // Counts edges since acceptance; reaches N+SUM_LAT on the final capture.
  localparam int CNT_W = $clog2(N + 2 + SUM_LAT);
  localparam logic [CNT_W-1:0] C_LAST_CNT  = CNT_W'(N + SUM_LAT);
  localparam logic [CNT_W-1:0] C_SHIFT_END = CNT_W'(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     sra_q, sra_d;
  logic [N-1:0]     srb_q, srb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N:0]       cap_q, cap_d;
  logic [N:0]       sum_q, sum_d;
  logic             done_q, done_d;

  logic             busy;
  logic             accept;
  logic             finish;
  logic             cap_en;
  logic [N:0]       cap_next;

  assign busy     = (state_q != S_IDLE);
  assign accept   = (state_q == S_IDLE) && bus.start;
  assign finish   = busy && (cnt_q == C_LAST_CNT);
  // With a registered adder the first edge after accept has no valid s_in.
  assign cap_en   = (SUM_LAT == 0) || (cnt_q != '0);
  assign cap_next = {bus.s_in, cap_q[N:1]};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sra_q   <= '0;
      srb_q   <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sra_q   <= sra_d;
      srb_q   <= srb_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sra_d   = sra_q;
    srb_d   = srb_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    sum_d   = sum_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sra_d   = bus.opa;
          srb_d   = bus.opb;
          cnt_d   = '0;
          cap_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT, S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        // Zero fill makes the (N+1)th presentation the 0/0 flush pair and
        // leaves a/b at zero through DRAIN.
        if (state_q == S_SHIFT) begin
          sra_d = {1'b0, sra_q[N-1:1]};
          srb_d = {1'b0, srb_q[N-1:1]};
        end
        if (cap_en) begin
          cap_d = cap_next;
        end
        if (cnt_q == C_LAST_CNT) begin
          // Take the final bit straight from s_in so sum updates atomically.
          sum_d   = cap_next;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if ((state_q == S_SHIFT) && (cnt_q == C_SHIFT_END)) begin
          state_d = S_DRAIN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.a    = busy & sra_q[0];
  assign bus.b    = busy & srb_q[0];
  assign bus.busy = busy;
  assign bus.sum  = sum_q;
  assign bus.done = done_q;

`ifdef SERIAL_ADD_SELFCHECK_EN
  logic [N:0] ref_q;
  logic       mismatch_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (accept) begin
        ref_q <= {1'b0, bus.opa} + {1'b0, bus.opb};
      end
      if (finish) begin
        mismatch_q <= (cap_next != ref_q);
      end
    end
  end

  assign bus.mismatch = mismatch_q;
`else
  logic unused_selfcheck;
  assign unused_selfcheck = accept ^ finish;
  assign bus.mismatch     = 1'b0;
`endif

endmodule

`default_nettype wire
